// File: rtl/serializador_tx_pkg.sv
// Shared definitions for the serial byte link (transmitter and receiver).
// Provides the transmitter state encoding, the byte width and the even-parity
// helper that both ends of the link use.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      NEXT
   } tx_state_t;

   localparam int BYTE_W = 8;

   // Even parity bit: XOR of all data bits, so data plus parity has an even
   // number of ones.
   function automatic logic even_parity(input logic [BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/serializador_tx_if.sv
// Bus bundle for serializador_tx: the parallel write/ack handshake from the
// local source plus the serial strobe/busy link toward the receiver.
interface serializador_tx_if;
   import serial_pkg::*;

   logic [BYTE_W-1:0] data_in;
   logic              write_in;
   logic              ack_out;
   logic              busy_in;
   logic              data_out;
   logic              write_out;
   logic              status_out;

   // The transmitter side of the bundle.
   modport slave (
      input  data_in,
      input  write_in,
      input  busy_in,
      output ack_out,
      output data_out,
      output write_out,
      output status_out
   );

   // The side that feeds bytes in and watches the serial stream.
   modport master (
      output data_in,
      output write_in,
      output busy_in,
      input  ack_out,
      input  data_out,
      input  write_out,
      input  status_out
   );

endinterface

// File: rtl/serializador_tx_tick_gen.sv
// Bit-slot tick generator: free-running counter 0..DIV-1 with a one-cycle tick
// on the last count. Never restarted by traffic, so bit slots stay on a fixed
// grid relative to reset.
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clock1M,
   input  logic reset,
   output logic tick
);

   localparam logic [9:0] LAST = 10'(DIV - 1);

   logic [9:0] count;

   // Wrapping slot counter, cleared only by reset.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 10'd1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/serializador_tx.sv
// serializador_tx: takes a byte over a write/ack handshake into a one-byte
// holding register and shifts it out one bit per slot as data_out plus a
// one-cycle write_out strobe, pausing while busy_in is high on a tick.
// Optional macro SERIALIZADOR_PARITY_EN appends an even-parity bit as a 9th
// serial bit.
module serializador_tx
   import serial_pkg::*;
#(
   parameter int DIV       = 10,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clock1M,
   input  logic               reset,
   serializador_tx_if.slave   bus
);

`ifdef SERIALIZADOR_PARITY_EN
   localparam int NBITS = BYTE_W + 1;
`else
   localparam int NBITS = BYTE_W;
`endif

   localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

   logic              tick;
   tx_state_t         state;
   logic [BYTE_W-1:0] holding;
   logic              holding_full;
   logic [NBITS-1:0]  shreg;
   logic [3:0]        bit_count;
   logic              data_q;
   logic              write_q;
   logic              ack_q;

   tick_gen #(
      .DIV(DIV)
   ) u_tick (
      .clock1M(clock1M),
      .reset  (reset),
      .tick   (tick)
   );

   // Word placed in the shift register on load. With parity the parity bit
   // sits on the side that leaves last, so it follows the 8 data bits.
   function automatic logic [NBITS-1:0] load_word(input logic [BYTE_W-1:0] b);
`ifdef SERIALIZADOR_PARITY_EN
      if (MSB_FIRST) begin
         return {b, even_parity(b)};
      end else begin
         return {even_parity(b), b};
      end
`else
      return b;
`endif
   endfunction

   // Bit that goes out next, taken from the end facing the wire.
   function automatic logic out_bit(input logic [NBITS-1:0] s);
      return MSB_FIRST ? s[NBITS-1] : s[0];
   endfunction

   // Register after one bit has left.
   function automatic logic [NBITS-1:0] shifted(input logic [NBITS-1:0] s);
      return MSB_FIRST ? {s[NBITS-2:0], 1'b0} : {1'b0, s[NBITS-1:1]};
   endfunction

   // Handshake, holding register and shift FSM in one block. Accept needs the
   // holding register empty and unload needs it full, so they never collide.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         holding      <= '0;
         holding_full <= 1'b0;
         shreg        <= '0;
         bit_count    <= '0;
         data_q       <= 1'b0;
         write_q      <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         write_q <= 1'b0;

         if (bus.write_in && !holding_full) begin
            holding      <= bus.data_in;
            holding_full <= 1'b1;
            ack_q        <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (holding_full) begin
                  shreg        <= load_word(holding);
                  holding_full <= 1'b0;
                  bit_count    <= '0;
                  state        <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick && !bus.busy_in) begin
                  data_q    <= out_bit(shreg);
                  write_q   <= 1'b1;
                  shreg     <= shifted(shreg);
                  bit_count <= bit_count + 4'd1;
                  if (bit_count == LAST_BIT) begin
                     state <= NEXT;
                  end
               end
            end
            NEXT: begin
               if (holding_full) begin
                  shreg        <= load_word(holding);
                  holding_full <= 1'b0;
                  bit_count    <= '0;
                  state        <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack_out    = ack_q;
   assign bus.data_out   = data_q;
   assign bus.write_out  = write_q;
   assign bus.status_out = holding_full;

endmodule

// File: doc/serializador_tx.md
Name: serializador_tx

Overview:
- Transmit-side companion of the bit-serial byte receiver.
- Accepts a parallel byte from a local source with a write/ack handshake and stores it in a one-byte holding register.
- Shifts the byte out one bit per 100 kHz bit slot, derived from clock1M, as a data bit plus a one-cycle write strobe. These drive the receiver's data_in/write_in.
- Honours a busy input, normally wired to the receiver's status_out, as bit-level backpressure.

Parameters:
- DIV, 10: clock1M cycles per bit slot (1 MHz / 10 = 100 kHz); legal range 2..1023.
- MSB_FIRST, 1: 1 sends bit 7 first (matches the receiver's left shift); 0 sends bit 0 first.

Ports:
- clock1M  in  1  system clock, 1 MHz.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- data_in  in  8  byte to transmit; sampled when the byte is accepted.
- write_in  in  1  source request; held high until ack_out.
- ack_out  out  1  one-cycle pulse: byte accepted this cycle.
- busy_in  in  1  downstream busy; while 1, no bit is emitted.
- data_out  out  1  serial bit; valid while write_out = 1, held afterwards.
- write_out  out  1  one-cycle strobe: data_out carries a new bit.
- status_out  out  1  1 while the holding register is full (new byte cannot be accepted).

Behaviour:
- Reset (reset = 0, async):
  - Outputs: data_out = 0, write_out = 0, ack_out = 0, status_out = 0.
  - Internal: holding register empty, shift register = 0, bit count = 0, slot counter = 0, state = IDLE.
- Slot counter: free-running 0..DIV-1; tick = 1 for one cycle when count = DIV-1, then wraps to 0. Runs in every state and is never restarted by traffic.
- Accept: on a clock edge where write_in = 1 and holding is empty:
  - data_in is latched into holding.
  - ack_out = 1 for that cycle only (registered, visible the cycle after the edge).
  - status_out goes 1.
- write_in while holding is full: ignored, no ack; the source keeps write_in high.
- State machine:
  - IDLE: if holding is full, copy holding to the shift register, clear holding (status_out goes 0 the same edge), bit count = 0, go to SHIFT.
  - SHIFT: on tick with busy_in = 0:
    - data_out = next bit (MSB or LSB per MSB_FIRST), write_out = 1 for one cycle.
    - Shift the register and increment the bit count.
    - On tick with busy_in = 1: nothing is emitted; retry at the next tick.
    - After the last bit (bit count reaches NBITS), go to NEXT.
  - NEXT: if holding is full, reload exactly as IDLE and return to SHIFT; else go to IDLE. Always one cycle.
- NBITS = 8, or 9 with the optional feature.
- busy_in is sampled only on tick cycles.
- Minimum spacing between write_out pulses is DIV cycles.
- Latency: first write_out arrives at the first tick at least 2 cycles after the ack edge (accept, then load).
- Simultaneous events:
  - Accept and unload in the same cycle cannot occur, because accept requires holding empty.
  - A byte may be accepted while SHIFT is active (double buffering); it is sent back-to-back via NEXT.
- Reset mid-byte: the partial byte and the held byte are discarded; write_out is low immediately.

Optional Feature:
- Macro: SERIALIZADOR_PARITY_EN.
- Defined: after the 8 data bits, a 9th bit is sent carrying even parity (XOR of the 8 data bits), computed when the shift register is loaded. It obeys the same tick/busy_in rules, and NBITS = 9.
- Undefined: only 8 data bits are sent, and no parity logic is present.

Decomposition:
- Shared package serial_pkg:
  - state enum tx_state_t {IDLE, SHIFT, NEXT}.
  - localparam BYTE_W = 8.
  - function even_parity(logic [7:0]).
  - The receiver reuses BYTE_W and even_parity.
- Sub-module tick_gen (parameter DIV; ports clock1M, reset, tick). Also reusable to put the receiver on 100 kHz.

Test Plan:
- Reset then write_in = 1, data_in = 8'hA5, busy_in = 0 -> one ack_out pulse; 8 write_out pulses DIV cycles apart with data_out 1,0,1,0,0,1,0,1; status_out 1 only between accept and load.
- Two bytes 8'h3C then 8'hFF offered back-to-back -> second ack while first byte is shifting; 16 strobes with no extra gap beyond DIV; order 0,0,1,1,1,1,0,0,1×8.
- 8'h81 with busy_in held 1 for 3 ticks after the first bit -> bit 2 is delayed exactly 3 ticks; total of exactly 8 strobes, none duplicated.
- Holding full and write_in = 1 with 8'h55 -> no ack, status_out = 1; ack arrives the cycle after the load; 8'h55 is then transmitted intact.
- reset = 0 pulse after 4 bits of 8'hF0 -> write_out/data_out/status_out are 0 asynchronously; a following byte 8'h0F is sent complete from bit 7.
- SERIALIZADOR_PARITY_EN defined, 8'h07 -> 9 strobes, last bit = 1; with 8'h03, last bit = 0.
